obj_sprite_layer: RTL and testbench

- Multi-object sprite/terrain layer. Holds a table of N_OBJ rectangular objects. Each object has a screen pivot, a size and a source-memory pivot.
- For each VGA pixel it produces the source-memory address, an enable and the winning object index, through a fixed 2-stage pipeline.
- Accumulates per-frame pixel-overlap collision flags against two player rectangles.
- Sits between the VGA timing generator and the sprite block-memory. It is the parametrised successor of the single-object terrain address generator, adding an object table, double buffering and collision flags.

---
 rtl/obj_pkg.sv | 43 ++++
 rtl/obj_hit.sv | 29 ++
 rtl/obj_sprite_layer.sv | 168 ++++++++++++++++
 tb/tb_obj_sprite_layer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared types for the sprite layer: object table entries, player rectangles
// and the overflow-safe containment test used by both hit and collision logic.
package obj_pkg;

  localparam int COORD_W = 10;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] pivot_h;
    logic [COORD_W-1:0] pivot_v;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic [COORD_W-1:0] mem_h;
    logic [COORD_W-1:0] mem_v;
  } obj_entry_t;

  typedef struct packed {
    logic [COORD_W-1:0] pivot_h;
    logic [COORD_W-1:0] pivot_v;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
  } rect_t;

  // One extra bit on the far edge keeps pivot+size from wrapping past 1023.
  function automatic logic in_rect(input logic [COORD_W-1:0] h,
                                   input logic [COORD_W-1:0] v,
                                   input rect_t              r);
    logic [COORD_W:0] h_ext;
    logic [COORD_W:0] v_ext;
    logic [COORD_W:0] h_lo;
    logic [COORD_W:0] v_lo;
    logic [COORD_W:0] h_hi;
    logic [COORD_W:0] v_hi;
    h_ext = {1'b0, h};
    v_ext = {1'b0, v};
    h_lo  = {1'b0, r.pivot_h};
    v_lo  = {1'b0, r.pivot_v};
    h_hi  = h_lo + {1'b0, r.width};
    v_hi  = v_lo + {1'b0, r.height};
    return (h_ext >= h_lo) && (h_ext < h_hi) && (v_ext >= v_lo) && (v_ext < v_hi);
  endfunction

endpackage

// File: rtl/obj_hit.sv
// Per-object hit test and source-memory address for one table entry.
// The address is only meaningful when hit is asserted.
module obj_hit
  import obj_pkg::*;
#(
  parameter int MEM_W  = 320,
  parameter int ADDR_W = 17
) (
  input  obj_entry_t         entry,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] v,
  output logic               hit,
  output logic [ADDR_W-1:0]  addr
);

  rect_t       obj_rect;
  logic [31:0] col;
  logic [31:0] row;

  always_comb begin
    obj_rect = '{pivot_h: entry.pivot_h, pivot_v: entry.pivot_v,
                 width:   entry.width,   height:  entry.height};
    hit  = entry.valid && in_rect(h, v, obj_rect);
    col  = 32'(h) - 32'(entry.pivot_h) + 32'(entry.mem_h);
    row  = 32'(v) - 32'(entry.pivot_v) + 32'(entry.mem_v);
    addr = ADDR_W'(col + row * 32'(MEM_W));
  end

endmodule

// File: rtl/obj_sprite_layer.sv
// Multi-object sprite layer: double-buffered object table, 2-stage pixel
// pipeline with lowest-index priority, and per-frame player collision flags.
module obj_sprite_layer
  import obj_pkg::*;
#(
  parameter int N_OBJ       = 4,
  parameter int IDX_W       = 2,
  parameter int MEM_W       = 320,
  parameter int ADDR_W      = 17,
  parameter int SCALE_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        vga_h,
  input  logic [9:0]        vga_v,
  input  logic              frame_end,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_valid,
  input  logic [9:0]        wr_pivot_h,
  input  logic [9:0]        wr_pivot_v,
  input  logic [9:0]        wr_width,
  input  logic [9:0]        wr_height,
  input  logic [9:0]        wr_mem_h,
  input  logic [9:0]        wr_mem_v,
  input  logic [39:0]       p1_rect,
  input  logic [39:0]       p2_rect,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic [IDX_W-1:0]  obj_id,
  output logic              collision_with_player1,
  output logic              collision_with_player2
);

  obj_entry_t shadow_q [N_OBJ];
  obj_entry_t shadow_d [N_OBJ];
  obj_entry_t active_q [N_OBJ];
  obj_entry_t active_d [N_OBJ];
  obj_entry_t wr_entry;

  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;

  logic [N_OBJ-1:0]   hit;
  logic [ADDR_W-1:0]  hit_addr [N_OBJ];

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               en_q, en_d;
  logic [IDX_W-1:0]   obj_id_q, obj_id_d;

  logic               sticky1_q, sticky1_d;
  logic               sticky2_q, sticky2_d;
  logic               col1_q, col1_d;
  logic               col2_q, col2_d;
  logic               p1_now;
  logic               p2_now;
  rect_t              p1_r;
  rect_t              p2_r;

  assign p1_r = p1_rect;
  assign p2_r = p2_rect;

  always_comb begin
    wr_entry = '{valid:  wr_valid,  pivot_h: wr_pivot_h, pivot_v: wr_pivot_v,
                 width:  wr_width,  height:  wr_height,
                 mem_h:  wr_mem_h,  mem_v:   wr_mem_v};
  end

  // Commit reads shadow_q, so a coincident write lands only in the shadow copy.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (frame_end) begin
      active_d = shadow_q;
    end
    if (wr_en) begin
      for (int k = 0; k < N_OBJ; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          shadow_d[k] = wr_entry;
        end
      end
    end
  end

  always_comb begin
    h_d = vga_h >> SCALE_SHIFT;
    v_d = vga_v >> SCALE_SHIFT;
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    obj_hit #(
      .MEM_W  (MEM_W),
      .ADDR_W (ADDR_W)
    ) u_obj_hit (
      .entry (active_q[g]),
      .h     (h_q),
      .v     (v_q),
      .hit   (hit[g]),
      .addr  (hit_addr[g])
    );
  end

  // Descending scan: the last match assigned is the lowest hitting index.
  always_comb begin
    en_d     = 1'b0;
    obj_id_d = '0;
    addr_d   = '0;
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        en_d     = 1'b1;
        obj_id_d = IDX_W'(k);
        addr_d   = hit_addr[k];
      end
    end
  end

  always_comb begin
    p1_now    = en_d && in_rect(h_q, v_q, p1_r);
    p2_now    = en_d && in_rect(h_q, v_q, p2_r);
    sticky1_d = sticky1_q | p1_now;
    sticky2_d = sticky2_q | p2_now;
    col1_d    = col1_q;
    col2_d    = col2_q;
    if (frame_end) begin
      col1_d    = sticky1_q | p1_now;
      col2_d    = sticky2_q | p2_now;
      sticky1_d = 1'b0;
      sticky2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_OBJ; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      obj_id_q  <= '0;
      sticky1_q <= 1'b0;
      sticky2_q <= 1'b0;
      col1_q    <= 1'b0;
      col2_q    <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      h_q       <= h_d;
      v_q       <= v_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      obj_id_q  <= obj_id_d;
      sticky1_q <= sticky1_d;
      sticky2_q <= sticky2_d;
      col1_q    <= col1_d;
      col2_q    <= col2_d;
    end
  end

  assign addr                   = addr_q;
  assign en                     = en_q;
  assign obj_id                 = obj_id_q;
  assign collision_with_player1 = col1_q;
  assign collision_with_player2 = col2_q;

endmodule

// File: tb/tb_obj_sprite_layer.sv
// Directed bench for obj_sprite_layer: hit/boundary/priority, table double
// buffering, collision flags and mid-frame reset, with hand-computed values.
module tb_obj_sprite_layer;

  logic        clk;
  logic        rst;
  logic [9:0]  vga_h;
  logic [9:0]  vga_v;
  logic        frame_end;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic        wr_valid;
  logic [9:0]  wr_pivot_h;
  logic [9:0]  wr_pivot_v;
  logic [9:0]  wr_width;
  logic [9:0]  wr_height;
  logic [9:0]  wr_mem_h;
  logic [9:0]  wr_mem_v;
  logic [39:0] p1_rect;
  logic [39:0] p2_rect;
  logic [16:0] addr;
  logic        en;
  logic [1:0]  obj_id;
  logic        col1;
  logic        col2;

  int n_tests = 0;
  int n_fail  = 0;

  obj_sprite_layer #(
    .N_OBJ       (4),
    .IDX_W       (2),
    .MEM_W       (320),
    .ADDR_W      (17),
    .SCALE_SHIFT (1)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .vga_h                  (vga_h),
    .vga_v                  (vga_v),
    .frame_end              (frame_end),
    .wr_en                  (wr_en),
    .wr_idx                 (wr_idx),
    .wr_valid               (wr_valid),
    .wr_pivot_h             (wr_pivot_h),
    .wr_pivot_v             (wr_pivot_v),
    .wr_width               (wr_width),
    .wr_height              (wr_height),
    .wr_mem_h               (wr_mem_h),
    .wr_mem_v               (wr_mem_v),
    .p1_rect                (p1_rect),
    .p2_rect                (p2_rect),
    .addr                   (addr),
    .en                     (en),
    .obj_id                 (obj_id),
    .collision_with_player1 (col1),
    .collision_with_player2 (col2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int h, input int v);
    vga_h = 10'(h);
    vga_v = 10'(v);
    step();
    step();
  endtask

  task automatic frame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic set_wr(input int idx, input logic valid, input int ph, input int pv,
                        input int w, input int hh, input int mh, input int mv);
    wr_idx     = 2'(idx);
    wr_valid   = valid;
    wr_pivot_h = 10'(ph);
    wr_pivot_v = 10'(pv);
    wr_width   = 10'(w);
    wr_height  = 10'(hh);
    wr_mem_h   = 10'(mh);
    wr_mem_v   = 10'(mv);
  endtask

  task automatic wr(input int idx, input logic valid, input int ph, input int pv,
                    input int w, input int hh, input int mh, input int mv);
    set_wr(idx, valid, ph, pv, w, hh, mh, mv);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic chk_px(input string tag, input logic e, input int id, input int a);
    chk({tag, "_en"}, 32'(en), 32'(e));
    chk({tag, "_id"}, 32'(obj_id), 32'(id));
    chk({tag, "_addr"}, 32'(addr), 32'(a));
  endtask

  initial begin
    rst       = 1'b1;
    vga_h     = 10'd600;
    vga_v     = 10'd400;
    frame_end = 1'b0;
    wr_en     = 1'b0;
    set_wr(0, 1'b0, 0, 0, 0, 0, 0, 0);
    p1_rect   = '0;
    p2_rect   = '0;
    step();
    step();
    chk_px("reset", 1'b0, 0, 0);
    chk("reset_col1", 32'(col1), 0);
    chk("reset_col2", 32'(col2), 0);
    rst = 1'b0;
    step();

    // basic hit and boundaries
    wr(0, 1'b1, 10, 20, 16, 8, 0, 0);
    frame();
    pixel(24, 42);  chk_px("basic",   1'b1, 0, 322);
    pixel(52, 42);  chk_px("h_edge",  1'b0, 0, 0);
    pixel(20, 40);  chk_px("corner",  1'b1, 0, 0);
    pixel(24, 56);  chk_px("v_edge",  1'b0, 0, 0);
    pixel(50, 54);  chk_px("last_in", 1'b1, 0, 2255);

    // priority
    wr(1, 1'b1, 10, 20, 16, 8, 100, 0);
    frame();
    pixel(24, 42);  chk_px("prio_both", 1'b1, 0, 322);
    wr(0, 1'b0, 10, 20, 16, 8, 0, 0);
    frame();
    pixel(24, 42);  chk_px("prio_obj1", 1'b1, 1, 422);

    // shadow write is invisible until frame_end
    wr(0, 1'b1, 50, 50, 16, 8, 0, 0);
    step();
    step();
    chk_px("shadow_hold", 1'b1, 1, 422);
    frame();
    pixel(100, 100); chk_px("shadow_commit", 1'b1, 0, 0);

    // write coincident with frame_end
    set_wr(1, 1'b0, 10, 20, 16, 8, 100, 0);
    wr_en     = 1'b1;
    frame_end = 1'b1;
    step();
    wr_en     = 1'b0;
    frame_end = 1'b0;
    pixel(24, 42);  chk_px("coinc_old", 1'b1, 1, 422);
    frame();
    pixel(24, 42);  chk_px("coinc_new", 1'b0, 0, 0);

    // collision, sticky within a frame
    wr(0, 1'b1, 10, 20, 16, 8, 0, 0);
    frame();
    chk("col1_idle", 32'(col1), 0);
    p1_rect = {10'd12, 10'd21, 10'd4, 10'd4};
    pixel(24, 42);
    chk("col_pix_en", 32'(en), 1);
    chk("col1_stable", 32'(col1), 0);
    vga_h = 10'd600;
    vga_v = 10'd400;
    step();
    step();
    frame();
    chk("col1_set", 32'(col1), 1);
    chk("col2_clear", 32'(col2), 0);
    step();
    step();
    chk("col1_hold", 32'(col1), 1);
    frame();
    chk("col1_next", 32'(col1), 0);

    // hit on the frame_end cycle itself counts, player 2 path
    p1_rect = '0;
    p2_rect = {10'd12, 10'd21, 10'd4, 10'd4};
    vga_h = 10'd24;
    vga_v = 10'd42;
    step();
    frame();
    chk("col2_now", 32'(col2), 1);
    chk("col1_now", 32'(col1), 0);

    // asynchronous reset mid-frame
    step();
    chk("pre_rst_en", 32'(en), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_px("rst_async", 1'b0, 0, 0);
    chk("rst_col2", 32'(col2), 0);
    step();
    rst = 1'b0;
    pixel(24, 42);  chk_px("rst_empty", 1'b0, 0, 0);
    wr(0, 1'b1, 10, 20, 16, 8, 0, 0);
    step();
    chk("rst_uncommitted", 32'(en), 0);
    frame();
    pixel(24, 42);  chk_px("rst_recommit", 1'b1, 0, 322);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
